mxu_tile_sequencer: RTL and testbench
=====================================

MXU_TILE_SEQUENCER -- requirements
Module: mxu_tile_sequencer

Interface
REQ-001 SHALL have parameters: ROWS, default 3, MXU rows; COLUMNS, default 3, MXU columns; ADDRESS_SIZE_WMEMORY, default 32, weight-memory address width.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cs_start  in  1  job request from PS.
- cs_continue  in  1  PS acknowledges done.
- cs_idle  out  1  FSM in IDLE.
- cs_ready  out  1  start accepted this cycle.
- cs_done  out  1  job complete; held until continue.
- num_tiles  in  16  tiles per job, sampled on start.
- wm_base  in  ADDRESS_SIZE_WMEMORY  first weight word address, sampled on start.
- wm_ce  out  1  weight BRAM read enable.
- wm_address  out  ADDRESS_SIZE_WMEMORY  weight BRAM word address.
- infifo_is_empty  in  1  high = input FIFO empty.
- infifo_read  out  1  input FIFO pop.
- load_data  out  1  capture FIFO/BRAM data into MXU input registers.
- enable_mxu  out  1  MXU compute enable.
- enable_enskew_ff  out  1  input skew registers enable.
- enable_deskew_ff  out  1  output deskew registers enable.
- outfifo_is_full  in  1  high = output FIFO full.
- outfifo_write  out  1  output FIFO push.
- stall_cycles  out  32  stall counter (see Configuration).

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, LOAD, COMPUTE, WRITE, DONE.
REQ-005 IDLE: cs_idle=1; on cs_start=1 SHALL pulse cs_ready one cycle, latch num_tiles/wm_base, clear tile index; go to DONE if num_tiles=0, else FETCH.
REQ-006 FETCH: when infifo_is_empty=0 SHALL assert wm_ce and infifo_read for exactly one cycle with wm_address=latched wm_base+tile index, then go to LOAD; while empty SHALL hold in FETCH with both strobes low.
REQ-007 LOAD: SHALL assert load_data one cycle (one-cycle BRAM/FIFO read latency), then go to COMPUTE.
REQ-008 COMPUTE: SHALL assert enable_mxu, enable_enskew_ff and enable_deskew_ff for exactly ROWS+COLUMNS-1 consecutive cycles (5 at defaults), then go to WRITE.
REQ-009 WRITE: when outfifo_is_full=0 SHALL assert outfifo_write one cycle, increment tile index; go to FETCH if tile index+1<latched num_tiles, else DONE; while full SHALL hold with outfifo_write low and MXU enables low.
REQ-010 DONE: SHALL hold cs_done=1 until cs_continue=1, then return to IDLE next cycle; cs_done deasserts in that cycle.
REQ-011 cs_start outside IDLE SHALL be ignored; num_tiles/wm_base changes after latching SHALL have no effect.
REQ-012 Tile index SHALL be 16 bits; address addition SHALL wrap modulo 2^ADDRESS_SIZE_WMEMORY.
REQ-013 All strobes SHALL be registered outputs; wm_address SHALL hold its last value when wm_ce=0.
REQ-014 cs_start and cs_continue high together in DONE: continue honoured, start ignored until IDLE.

Reset
REQ-015 On reset=1, asynchronously: state IDLE, cs_idle=1, every other output 0, wm_address=0, counters 0.
REQ-016 Reset mid-job SHALL abort immediately; no further strobe after reset asserts; after release, a new cs_start is required.

Configuration
REQ-017 Macro SEQ_STALL_CNT_EN defined: stall_cycles SHALL count cycles in FETCH with infifo_is_empty=1 plus cycles in WRITE with outfifo_is_full=1, cleared on accepted start, saturating at 2^32-1.
REQ-018 Macro undefined: stall_cycles SHALL be constant 0, no counter logic.

Verification
REQ-019 num_tiles=1, wm_base=0x10, FIFOs ready: start -> ready at cycle 0; wm_ce/infifo_read cycle 1 with address 0x10; load_data cycle 2; enable_mxu cycles 3-7; outfifo_write cycle 8; cs_done from cycle 9.
REQ-020 num_tiles=3, wm_base=0xFFFFFFFE: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0; exactly 3 outfifo_write pulses.
REQ-021 num_tiles=0: start -> cs_done next cycle, no wm_ce/infifo_read/outfifo_write.
REQ-022 infifo empty 4 cycles in FETCH, outfifo full 3 cycles in WRITE: no strobes during stalls; with SEQ_STALL_CNT_EN stall_cycles=7, without =0.
REQ-023 Reset asserted during the 3rd COMPUTE cycle -> all outputs 0 and cs_idle=1 same cycle; cs_start pulsed after release restarts the job from tile 0.
REQ-024 cs_start held high during a 2-tile job -> exactly one cs_ready pulse; cs_continue pulse in DONE -> IDLE next cycle.

Source files
------------

// File: rtl/mxu_tile_sequencer.sv
// mxu_tile_sequencer: per-tile FETCH/LOAD/COMPUTE/WRITE control for the MXU.
// Ports: clk, reset (async, active-high); cs_start/cs_continue/num_tiles/
//   wm_base in, cs_idle/cs_ready/cs_done out (PS handshake);
//   wm_ce/wm_address (weight BRAM); infifo_is_empty in, infifo_read out;
//   load_data, enable_mxu, enable_enskew_ff, enable_deskew_ff (MXU);
//   outfifo_is_full in, outfifo_write out; stall_cycles out.
// Option: define SEQ_STALL_CNT_EN to build the FIFO stall counter;
//   without it stall_cycles is tied to zero.
module mxu_tile_sequencer #(
  parameter int ROWS                 = 3,
  parameter int COLUMNS              = 3,
  parameter int ADDRESS_SIZE_WMEMORY = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cs_start,
  input  logic                            cs_continue,
  output logic                            cs_idle,
  output logic                            cs_ready,
  output logic                            cs_done,
  input  logic [15:0]                     num_tiles,
  input  logic [ADDRESS_SIZE_WMEMORY-1:0] wm_base,
  output logic                            wm_ce,
  output logic [ADDRESS_SIZE_WMEMORY-1:0] wm_address,
  input  logic                            infifo_is_empty,
  output logic                            infifo_read,
  output logic                            load_data,
  output logic                            enable_mxu,
  output logic                            enable_enskew_ff,
  output logic                            enable_deskew_ff,
  input  logic                            outfifo_is_full,
  output logic                            outfifo_write,
  output logic [31:0]                     stall_cycles
);

  localparam int AW   = ADDRESS_SIZE_WMEMORY;
  localparam int NCYC = ROWS + COLUMNS - 1;
  localparam int CW   = $clog2(NCYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     ntiles_q, ntiles_d;
  logic [AW-1:0]   base_q, base_d;
  logic [15:0]     tile_q, tile_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            idle_q, idle_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            fetch_q, fetch_d;
  logic            load_q, load_d;
  logic            en_q, en_d;
  logic            wr_q, wr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ntiles_q <= '0;
      base_q   <= '0;
      tile_q   <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      idle_q   <= 1'b1;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      fetch_q  <= 1'b0;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ntiles_q <= ntiles_d;
      base_q   <= base_d;
      tile_q   <= tile_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      idle_q   <= idle_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      fetch_q  <= fetch_d;
      load_q   <= load_d;
      en_q     <= en_d;
      wr_q     <= wr_d;
    end
  end

  // Strobes are computed one state ahead so every output is a flop.
  always_comb begin
    state_d  = state_q;
    ntiles_d = ntiles_q;
    base_d   = base_q;
    tile_d   = tile_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    fetch_d  = 1'b0;
    load_d   = 1'b0;
    en_d     = 1'b0;
    wr_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cs_start) begin
          ready_d  = 1'b1;
          ntiles_d = num_tiles;
          base_d   = wm_base;
          tile_d   = '0;
          state_d  = (num_tiles == 16'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!infifo_is_empty) begin
          fetch_d = 1'b1;
          addr_d  = base_q + AW'(tile_q);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        en_d  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NCYC - 1)) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!outfifo_is_full) begin
          wr_d   = 1'b1;
          tile_d = tile_q + 16'd1;
          // 17-bit compare so tile 0xFFFF+1 cannot wrap.
          if (({1'b0, tile_q} + 17'd1) < {1'b0, ntiles_q})
            state_d = S_FETCH;
          else
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (cs_continue) state_d = S_IDLE;
        else             done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    idle_d = (state_d == S_IDLE);
  end

  assign cs_idle          = idle_q;
  assign cs_ready         = ready_q;
  assign cs_done          = done_q;
  assign wm_ce            = fetch_q;
  assign infifo_read      = fetch_q;
  assign wm_address       = addr_q;
  assign load_data        = load_q;
  assign enable_mxu       = en_q;
  assign enable_enskew_ff = en_q;
  assign enable_deskew_ff = en_q;
  assign outfifo_write    = wr_q;

`ifdef SEQ_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic        stalled;

  assign stalled = (state_q == S_FETCH && infifo_is_empty) ||
                   (state_q == S_WRITE && outfifo_is_full);

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && cs_start)
      stall_d = '0;
    else if (stalled && stall_q != '1)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mxu_tile_sequencer.sv
// tb_mxu_tile_sequencer: randomized jobs checked against a cycle timeline
// derived from tile count, FIFO stalls and the compute length.
module tb_mxu_tile_sequencer;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_start, cs_continue;
  logic        cs_idle, cs_ready, cs_done;
  logic [15:0] num_tiles;
  logic [31:0] wm_base;
  logic        wm_ce;
  logic [31:0] wm_address;
  logic        infifo_is_empty, infifo_read;
  logic        load_data, enable_mxu;
  logic        enable_enskew_ff, enable_deskew_ff;
  logic        outfifo_is_full, outfifo_write;
  logic [31:0] stall_cycles;

  mxu_tile_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .cs_start         (cs_start),
    .cs_continue      (cs_continue),
    .cs_idle          (cs_idle),
    .cs_ready         (cs_ready),
    .cs_done          (cs_done),
    .num_tiles        (num_tiles),
    .wm_base          (wm_base),
    .wm_ce            (wm_ce),
    .wm_address       (wm_address),
    .infifo_is_empty  (infifo_is_empty),
    .infifo_read      (infifo_read),
    .load_data        (load_data),
    .enable_mxu       (enable_mxu),
    .enable_enskew_ff (enable_enskew_ff),
    .enable_deskew_ff (enable_deskew_ff),
    .outfifo_is_full  (outfifo_is_full),
    .outfifo_write    (outfifo_write),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  bit          xe[512], xfu[512], xce[512];
  bit          xld[512], xen[512], xwr[512];
  logic [31:0] xaddr[512];
  int          estall[16], fstall[16];
  logic [31:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic exp_outs(input bit i, input bit r, input bit d,
                          input bit ce, input bit ld, input bit en,
                          input bit wr, input logic [31:0] a);
    chk("cs_idle", 32'(cs_idle), 32'(i));
    chk("cs_ready", 32'(cs_ready), 32'(r));
    chk("cs_done", 32'(cs_done), 32'(d));
    chk("wm_ce", 32'(wm_ce), 32'(ce));
    chk("infifo_read", 32'(infifo_read), 32'(ce));
    chk("load_data", 32'(load_data), 32'(ld));
    chk("enable_mxu", 32'(enable_mxu), 32'(en));
    chk("enable_enskew", 32'(enable_enskew_ff), 32'(en));
    chk("enable_deskew", 32'(enable_deskew_ff), 32'(en));
    chk("outfifo_write", 32'(outfifo_write), 32'(wr));
    chk("wm_address", wm_address, a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle c = the period after the c-th rising edge; edge 0 samples start.
  task automatic run_job(input int nt, input logic [31:0] base,
                         input bit hold_start, input int h);
    int          s, d, e, f;
    logic [31:0] stall_exp, stall_ref;
    for (int i = 0; i < 512; i++) begin
      xe[i] = 0; xfu[i] = 0; xce[i] = 0;
      xld[i] = 0; xen[i] = 0; xwr[i] = 0;
      xaddr[i] = '0;
    end
    s = 0;
    stall_exp = 0;
    for (int t = 0; t < nt; t++) begin
      e = estall[t];
      f = fstall[t];
      for (int k = 0; k < e; k++) xe[s + k] = 1;
      xce[s + e + 1] = 1;
      xaddr[s + e + 1] = base + 32'(t);
      xld[s + e + 2] = 1;
      for (int k = 0; k < N; k++) xen[s + e + 3 + k] = 1;
      for (int k = 0; k < f; k++) xfu[s + e + 2 + N + k] = 1;
      s = s + e + 3 + N + f;
      xwr[s] = 1;
      stall_exp = stall_exp + 32'(e + f);
    end
    d = s + 1;
`ifdef SEQ_STALL_CNT_EN
    stall_ref = stall_exp;
`else
    stall_ref = 32'd0;
`endif
    num_tiles = 16'(nt);
    wm_base = base;
    cs_start = 1'b1;
    cs_continue = 1'b0;
    for (int c = 0; c <= d + h + 1; c++) begin
      tick();
      if (xce[c]) last_addr = xaddr[c];
      exp_outs(c == d + h + 1, c == 0, c >= d && c <= d + h,
               xce[c], xld[c], xen[c], xwr[c], last_addr);
      if (c == 0) chk("stall_clear", stall_cycles, 32'd0);
      if (c == d) chk("stall_total", stall_cycles, stall_ref);
      cs_start = hold_start && c <= d + h;
      cs_continue = (c == d + h);
      infifo_is_empty = xe[c];
      outfifo_is_full = xfu[c];
      num_tiles = 16'($urandom);
      wm_base = $urandom;
    end
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 16; i++) begin
      estall[i] = 0;
      fstall[i] = 0;
    end
  endtask

  task automatic reset_mid_compute(input logic [31:0] base);
    clear_stalls();
    num_tiles = 16'd2;
    wm_base = base;
    cs_start = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      tick();
      cs_start = 1'b0;
    end
    chk("mxu_before_rst", 32'(enable_mxu), 32'd1);
    #1 reset = 1'b1;
    #1 exp_outs(1, 0, 0, 0, 0, 0, 0, 32'd0);
    tick();
    exp_outs(1, 0, 0, 0, 0, 0, 0, 32'd0);
    #3 reset = 1'b0;
    last_addr = 32'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp_outs(1, 0, 0, 0, 0, 0, 0, 32'd0);
    end
    run_job(2, base, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    cs_start = 1'b0;
    cs_continue = 1'b0;
    num_tiles = '0;
    wm_base = '0;
    infifo_is_empty = 1'b0;
    outfifo_is_full = 1'b0;
    last_addr = 32'd0;
    #12;
    exp_outs(1, 0, 0, 0, 0, 0, 0, 32'd0);
    chk("stall_reset", stall_cycles, 32'd0);
    reset = 1'b0;
    tick();

    clear_stalls();
    run_job(1, 32'h10, 0, 0);
    run_job(3, 32'hFFFF_FFFE, 0, 1);
    run_job(0, 32'h1234, 0, 2);
    estall[0] = 4;
    fstall[0] = 3;
    run_job(1, 32'h40, 0, 0);
    clear_stalls();
    run_job(2, 32'h80, 1, 2);
    reset_mid_compute(32'h200);

    for (int j = 0; j < 24; j++) begin
      for (int i = 0; i < 16; i++) begin
        estall[i] = $urandom_range(0, 3);
        fstall[i] = $urandom_range(0, 3);
      end
      run_job($urandom_range(0, 5),
              ($urandom_range(0, 3) == 0) ?
                32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom,
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
